// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared FSM states and default dump range for the register dump reader
package reg_dump_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;
  localparam int unsigned DEF_FIRST_REG = 1;
  localparam int unsigned DEF_LAST_REG  = 31;
endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file read port and streams (index, data) words with a running checksum
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIRST_REG = DEF_FIRST_REG,
  parameter int unsigned LAST_REG  = DEF_LAST_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] a,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_REG);
  state_t state, nxt;
  logic [ADDR_W-1:0] idx;
  logic hs;
  assign hs   = state == SEND && out_valid && out_ready;
  assign ra   = state == IDLE ? '0 : idx;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = SEND;
      SEND:    nxt = !hs ? SEND : out_last ? DONE : LOAD;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // abort outranks both start and a same-cycle handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= FIRST;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      checksum  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start && !abort) begin
        idx      <= FIRST;
        checksum <= '0;
      end
      if (state == LOAD && !abort) begin
        out_data  <= a;
        out_index <= idx;
        out_last  <= idx == LAST;
        out_valid <= 1'b1;
      end
      if (hs && !abort) begin
        checksum  <= checksum + out_data;
        out_valid <= 1'b0;
        if (!out_last) idx <= idx + 1'b1;
      end
      if (abort) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: scenario table plus hand sequences against a list-of-words reference model
module tb_reg_dump_reader;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
  logic [4:0] ra, out_index;
  logic [31:0] a, out_data, checksum;
  logic out_valid, out_last, busy, done;
  logic [31:0] rf [32];
  logic [31:0] ref_rf [32];
  int n_cmp = 0, n_fail = 0;
  typedef struct { logic [4:0] idx; logic [31:0] data; logic last; } word_t;
  typedef struct { int mode; int abort_word; bit start_mid; bit wr; bit rnd; int words; logic [31:0] cs; int done_edge; } vec_t;
  word_t got[$];
  vec_t tbl[6];
  int done_cnt, done_edge;
  bit finished;

  always #5 clk = ~clk;
  assign a = rf[ra];

  reg_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ra(ra), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .checksum(checksum)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic init_rf(input bit rnd);
    for (int i = 0; i < 32; i++) begin
      rf[i] = (i == 0) ? 32'd0 : rnd ? $urandom : 32'(i);
      ref_rf[i] = rf[i];
    end
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0; abort = 0; out_ready = 0;
    cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic run(input vec_t v);
    bit pv, pr, pl, pa;
    logic [4:0] pi;
    logic [31:0] pd;
    got.delete();
    done_cnt = 0; done_edge = -1; finished = 0;
    start = 1;
    out_ready = (v.mode != 1);
    for (int e = 0; e < 400; e++) begin
      if (out_valid && out_ready && !abort) got.push_back('{out_index, out_data, out_last});
      pv = out_valid; pr = out_ready; pi = out_index; pd = out_data; pl = out_last; pa = abort;
      cyc();
      start = v.start_mid && e == 20;
      abort = 0;
      if (done) begin done_cnt++; done_edge = e; end
      if (pv && !pr && !pa) chk("stall_hold", {out_valid, out_index, out_data, out_last}, {1'b1, pi, pd, pl});
      if (pa) chk("abort_valid_drop", {out_valid, busy}, 2'b00);
      if (v.wr && e == 5) begin rf[6] = 32'h2; ref_rf[6] = 32'h2; end
      out_ready = v.mode == 0 ? 1'b1 : v.mode == 1 ? (e % 3 == 2) : 1'($urandom_range(0, 1));
      if (v.abort_word > 0 && out_valid && out_index == 5'(v.abort_word)) begin abort = 1; out_ready = 1; end
      if (!busy) begin finished = 1; break; end
    end
    out_ready = 0;
  endtask

  task automatic score(input int k, input vec_t v);
    int n;
    logic [31:0] cs;
    n = v.abort_word > 0 ? v.abort_word - 1 : 31;
    cs = 0;
    chk($sformatf("t%0d_finished", k), finished, 1);
    chk($sformatf("t%0d_word_count", k), got.size(), n);
    chk($sformatf("t%0d_table_count", k), got.size(), v.words);
    for (int i = 0; i < n; i++) begin
      cs += ref_rf[i + 1];
      if (i < got.size())
        chk($sformatf("t%0d_word%0d", k, i + 1), {got[i].idx, got[i].data, got[i].last},
            {5'(i + 1), ref_rf[i + 1], 1'(i + 1 == 31)});
    end
    chk($sformatf("t%0d_checksum_model", k), checksum, cs);
    if (!v.rnd) chk($sformatf("t%0d_checksum_const", k), checksum, v.cs);
    chk($sformatf("t%0d_done_count", k), done_cnt, v.done_edge == -1 ? 0 : 1);
    if (v.done_edge >= 0) chk($sformatf("t%0d_done_edge", k), done_edge, v.done_edge);
    chk($sformatf("t%0d_idle", k), {busy, out_valid, ra}, 0);
  endtask

  initial begin
    bit found;
    tbl[0] = '{0, 0, 0, 0, 0, 31, 32'h1F0, 62};
    tbl[1] = '{1, 0, 0, 0, 0, 31, 32'h1F0, -2};
    tbl[2] = '{0, 0, 0, 1, 0, 31, 32'h1E6, 62};
    tbl[3] = '{0, 10, 0, 0, 0, 9, 32'h2D, -1};
    tbl[4] = '{0, 0, 1, 0, 0, 31, 32'h1F0, 62};
    tbl[5] = '{2, 0, 0, 0, 1, 31, 32'h0, -2};
    init_rf(0);
    #2;
    chk("reset_outputs", {ra, out_valid, out_index, out_data, out_last, busy, done, checksum}, 0);
    do_reset();
    start = 1; abort = 1;
    cyc();
    start = 0; abort = 0;
    chk("start_abort_idle", {busy, ra}, 0);
    for (int k = 0; k < 6; k++) begin
      do_reset();
      init_rf(tbl[k].rnd);
      if (tbl[k].wr) begin rf[5] = 32'hFFFFFFFF; ref_rf[5] = 32'hFFFFFFFF; end
      run(tbl[k]);
      score(k, tbl[k]);
    end
    do_reset();
    init_rf(0);
    start = 1; out_ready = 1;
    cyc();
    start = 0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid && out_index == 5'd3) begin found = 1; out_ready = 0; break; end
      cyc();
    end
    chk("word3_reached", found, 1);
    chk("partial_checksum", checksum, 32'd3);
    #2;
    rst_n = 0;
    #1;
    chk("async_reset_outputs", {ra, out_valid, out_index, out_data, out_last, busy, done, checksum}, 0);
    cyc();
    rst_n = 1;
    start = 1;
    cyc();
    start = 0;
    chk("restart_load", {busy, ra}, {1'b1, 5'd1});
    cyc();
    chk("restart_word1", {out_valid, out_index, out_data, out_last}, {1'b1, 5'd1, 32'd1, 1'b0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
